hello_world_nios2_qsys_ocimem_arbiter: RTL and testbench

HELLO_WORLD_NIOS2_QSYS_OCIMEM_ARBITER -- requirements
Module: hello_world_nios2_qsys_ocimem_arbiter

---
 rtl/hello_world_nios2_qsys_ocimem_arb_pkg.sv | 27 ++
 rtl/hello_world_nios2_qsys_rr_arbiter2.sv | 48 ++++
 rtl/hello_world_nios2_qsys_ocimem_arbiter.sv | 145 ++++++++++++++
 tb/tb_hello_world_nios2_qsys_ocimem_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hello_world_nios2_qsys_ocimem_arb_pkg.sv
// +--------------------------------------------------------------------+
// | hello_world_nios2_qsys_ocimem_arb_pkg: shared types for OCI arbiter |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package hello_world_nios2_qsys_ocimem_arb_pkg;

  localparam int   DATA_W   = 32;
  localparam int   CNT_W    = 10;
  localparam logic REQ_JTAG = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hello_world_nios2_qsys_rr_arbiter2.sv
// +--------------------------------------------------------------------+
// | hello_world_nios2_qsys_rr_arbiter2: 2-way round robin with lock     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module hello_world_nios2_qsys_rr_arbiter2
  import hello_world_nios2_qsys_ocimem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic       lock,
  input  logic       enable,
  output logic       grant_valid,
  output logic       grant_idx,
  output logic [1:0] grant_onehot
);

  logic [1:0] eligible;
  logic       last_grant_q;
  logic       last_grant_d;

  always_comb begin
    eligible = {req_valid[1] & ~lock, req_valid[0]};
    grant_valid = |eligible;
    if (&eligible) begin
      grant_idx = ~last_grant_q;
    end else if (eligible[0]) begin
      grant_idx = REQ_JTAG;
    end else begin
      grant_idx = REQ_HOST;
    end
    grant_onehot = (enable && grant_valid) ? onehot2(grant_idx) : 2'b00;
    last_grant_d = (enable && grant_valid) ? grant_idx : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= REQ_HOST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hello_world_nios2_qsys_ocimem_arbiter.sv
// +--------------------------------------------------------------------+
// | hello_world_nios2_qsys_ocimem_arbiter: JTAG/HOST monitor-mem access |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module hello_world_nios2_qsys_ocimem_arbiter
  import hello_world_nios2_qsys_ocimem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          rq_valid,
  output logic [1:0]          rq_ready,
  input  logic [1:0]          rq_write,
  input  logic [2*ADDR_W-1:0] rq_addr,
  input  logic [63:0]         rq_wdata,
  input  logic                jtag_lock,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_error,
  output logic                mem_cs,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gnt_q, gnt_d;
  logic                mem_cs_q, mem_cs_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_error_q, rsp_error_d;

  logic                arb_valid;
  logic                arb_idx;

  hello_world_nios2_qsys_rr_arbiter2 u_rr (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (rq_valid),
    .lock         (jtag_lock),
    .enable       (state_q == ST_IDLE),
    .grant_valid  (arb_valid),
    .grant_idx    (arb_idx),
    .grant_onehot (rq_ready)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    mem_cs_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    unique case (state_q)
      ST_IDLE: begin
        // Payload is captured straight into the memory-side registers;
        // mem_cs qualifies them during ISSUE.
        if (arb_valid) begin
          gnt_d       = arb_idx;
          mem_cs_d    = 1'b1;
          mem_we_d    = rq_write[arb_idx];
          mem_addr_d  = arb_idx ? rq_addr[ADDR_W +: ADDR_W] : rq_addr[0 +: ADDR_W];
          mem_wdata_d = arb_idx ? rq_wdata[32 +: 32] : rq_wdata[0 +: 32];
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ack) begin
          rsp_valid_d = onehot2(gnt_q);
          rsp_rdata_d = mem_we_q ? '0 : mem_rdata;
          rsp_error_d = 1'b0;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d = onehot2(gnt_q);
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gnt_q       <= REQ_JTAG;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

`default_nettype wire

// File: tb/tb_hello_world_nios2_qsys_ocimem_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_hello_world_nios2_qsys_ocimem_arbiter: directed self-check bench |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_hello_world_nios2_qsys_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rq_valid;
  logic [1:0]  rq_ready;
  logic [1:0]  rq_write;
  logic [15:0] rq_addr;
  logic [63:0] rq_wdata;
  logic        jtag_lock;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_cs;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hello_world_nios2_qsys_ocimem_arbiter #(
    .TIMEOUT_CYCLES (4),
    .ADDR_W         (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rq_valid  (rq_valid),
    .rq_ready  (rq_ready),
    .rq_write  (rq_write),
    .rq_addr   (rq_addr),
    .rq_wdata  (rq_wdata),
    .jtag_lock (jtag_lock),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_ready [4];
    logic [7:0] exp_addr  [4];
    exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_addr  = '{8'h01, 8'h02, 8'h01, 8'h02};

    reset = 1'b1; rq_valid = 2'b00; rq_write = 2'b00; rq_addr = '0;
    rq_wdata = '0; jtag_lock = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_mem_cs", mem_cs, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_rq_ready", rq_ready, 0);

    // JTAG read of 0x10, ack in first WAIT cycle
    rq_valid = 2'b01; rq_addr = 16'h0010;
    #1 check("rd_ready_c0", rq_ready, 2'b01);
    tick(); rq_valid = 2'b00;
    check("rd_cs_c1", mem_cs, 1);
    check("rd_we_c1", mem_we, 0);
    check("rd_addr_c1", mem_addr, 8'h10);
    tick();
    check("rd_cs_c2", mem_cs, 0);
    check("rd_rspv_c2", rsp_valid, 0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
    tick(); mem_ack = 1'b0;
    check("rd_rspv_c3", rsp_valid, 2'b01);
    check("rd_rdata_c3", rsp_rdata, 32'hCAFE0001);
    check("rd_err_c3", rsp_error, 0);
    tick();
    check("rd_rspv_c4", rsp_valid, 0);
    check("rd_rdata_hold", rsp_rdata, 32'hCAFE0001);
    // stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick(); mem_ack = 1'b0;
    check("stray_idle_rspv", rsp_valid, 0);
    check("stray_idle_cs", mem_cs, 0);
    check("stray_idle_rdata", rsp_rdata, 32'hCAFE0001);

    // Round robin with both requesters continuously valid
    reset = 1'b1; tick(); reset = 1'b0;
    rq_valid = 2'b11; rq_addr = 16'h0201;
    for (int i = 0; i < 4; i++) begin
      #1 check("rr_ready", rq_ready, exp_ready[i]);
      tick();
      check("rr_cs", mem_cs, 1);
      check("rr_addr", mem_addr, exp_addr[i]);
      mem_ack = 1'b1; mem_rdata = 32'h100 + i;
      tick();
      check("rr_wait_rspv", rsp_valid, 0);
      tick();
      check("rr_rspv", rsp_valid, exp_ready[i]);
      check("rr_rdata", rsp_rdata, 32'h100 + i);
      tick(); mem_ack = 1'b0;
      check("rr_idle_rspv", rsp_valid, 0);
      if (i == 3) rq_valid = 2'b00;
    end

    // Lock holds off HOST
    rq_valid = 2'b10; jtag_lock = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1 check("lock_ready", rq_ready, 0);
      tick();
      check("lock_cs", mem_cs, 0);
    end
    jtag_lock = 1'b0;
    #1 check("unlock_ready", rq_ready, 2'b10);
    tick(); rq_valid = 2'b00; mem_rdata = 32'h55AA55AA;
    check("unlock_cs", mem_cs, 1);
    check("unlock_addr", mem_addr, 8'h02);
    // no ack: times out after 4 WAIT cycles
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_wait_rspv", rsp_valid, 0);
    end
    tick();
    check("to_rspv", rsp_valid, 2'b10);
    check("to_err", rsp_error, 1);
    check("to_rdata", rsp_rdata, 0);
    tick();
    check("to_err_hold", rsp_error, 1);

    // ack on the 4th WAIT cycle wins
    rq_valid = 2'b01; rq_addr = 16'h0020;
    tick(); rq_valid = 2'b00;
    tick(); tick(); tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    tick(); mem_ack = 1'b0;
    check("late_ack_rspv", rsp_valid, 2'b01);
    check("late_ack_err", rsp_error, 0);
    check("late_ack_rdata", rsp_rdata, 32'hA5A5A5A5);
    tick();

    // Reset during WAIT drops the access
    rq_valid = 2'b01;
    tick(); rq_valid = 2'b00;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_drop_rspv", rsp_valid, 0);
      check("rst_drop_cs", mem_cs, 0);
      mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    check("rst_drop_rspv_end", rsp_valid, 0);

    // HOST write after reset
    rq_valid = 2'b10; rq_write = 2'b10; rq_addr = 16'h3F00;
    rq_wdata = 64'h12345678_00000000;
    #1 check("wr_ready", rq_ready, 2'b10);
    tick(); rq_valid = 2'b00;
    check("wr_cs", mem_cs, 1);
    check("wr_we", mem_we, 1);
    check("wr_addr", mem_addr, 8'h3F);
    check("wr_wdata", mem_wdata, 32'h12345678);
    tick(); mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick(); mem_ack = 1'b0;
    check("wr_rspv", rsp_valid, 2'b10);
    check("wr_rdata", rsp_rdata, 0);
    check("wr_err", rsp_error, 0);
    tick();
    check("wr_idle_rspv", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
